// File: rtl/id_bypass_stage.sv
// Decode slot: register file, operand bypass and load-use interlock.
//
// Holds one pre-decoded instruction between IF and EX behind a
// valid/allowin handshake. The architectural register file lives here and
// is written by WB through a dedicated port, with write-through on reads.
//
// Build option: ID_BYPASS_EN
//   defined   - operands are forwarded from the youngest matching
//               channel; only a not-ready match interlocks.
//   undefined - no forwarding; any channel match interlocks and
//               operands come from the register file only.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   if_to_id_valid  IF offers an instruction
//   id_allowin      ID accepts the offer this cycle
//   if_payload      opaque decoded payload (ctrl, imm, pc)
//   if_src1_en/addr source 1 read enable / index
//   if_src2_en/addr source 2 read enable / index
//   if_gr_we        instruction writes a register
//   if_dest         destination register index
//   id_flush        branch flush, kills the slot
//   ex_allowin      EX can accept
//   id_to_ex_valid  ID offers an instruction to EX
//   id_reg          {payload, dest, gr_we, src1_val, src2_val}
//   id_stall        slot valid but held by an interlock
//   fwd_valid/we    per-channel valid / register write flags
//   fwd_addr        per-channel destination, packed [i*AW +: AW]
//   fwd_ready       per-channel result available
//   fwd_data        per-channel result, packed [i*DW +: DW]
//   wb_we/addr/wdata register-file write port

module id_bypass_stage #(
    parameter int DW        = 32,
    parameter int NREG      = 32,
    parameter int NFWD      = 2,
    parameter int PAYLOAD_W = 64,
    localparam int AW = $clog2(NREG),
    localparam int RW = PAYLOAD_W + AW + 1 + 2 * DW
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 if_to_id_valid,
    output logic                 id_allowin,
    input  logic [PAYLOAD_W-1:0] if_payload,
    input  logic                 if_src1_en,
    input  logic [AW-1:0]        if_src1_addr,
    input  logic                 if_src2_en,
    input  logic [AW-1:0]        if_src2_addr,
    input  logic                 if_gr_we,
    input  logic [AW-1:0]        if_dest,

    input  logic                 id_flush,
    input  logic                 ex_allowin,
    output logic                 id_to_ex_valid,
    output logic [RW-1:0]        id_reg,
    output logic                 id_stall,

    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD*AW-1:0]   fwd_addr,
    input  logic [NFWD-1:0]      fwd_ready,
    input  logic [NFWD*DW-1:0]   fwd_data,

    input  logic                 wb_we,
    input  logic [AW-1:0]        wb_addr,
    input  logic [DW-1:0]        wb_wdata
);

    // Slot state
    logic                 id_valid;
    logic [PAYLOAD_W-1:0] slot_payload;
    logic                 slot_src1_en;
    logic [AW-1:0]        slot_src1_addr;
    logic                 slot_src2_en;
    logic [AW-1:0]        slot_src2_addr;
    logic                 slot_gr_we;
    logic [AW-1:0]        slot_dest;

    logic                 id_ready_go;
    logic                 hazard;

    // Register file (not reset)
    logic [DW-1:0] rf [NREG];

    always_ff @(posedge clk) begin
        if (wb_we && (wb_addr != '0)) begin
            rf[wb_addr] <= wb_wdata;
        end
    end

    // Per-source views, index 0 = src1, 1 = src2
    logic [1:0]    src_en;
    logic [AW-1:0] src_addr [2];
    logic [DW-1:0] rf_rd    [2];
    logic [DW-1:0] opnd     [2];
    logic [1:0]    src_hit;
    logic [1:0]    src_haz;

    assign src_en[0]   = slot_src1_en;
    assign src_en[1]   = slot_src2_en;
    assign src_addr[0] = slot_src1_addr;
    assign src_addr[1] = slot_src2_addr;

    // Register-file read with write-through from WB
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            rf_rd[s] = '0;
            if (src_addr[s] == '0) begin
                rf_rd[s] = '0;
            end else if (wb_we && (wb_addr == src_addr[s])) begin
                rf_rd[s] = wb_wdata;
            end else begin
                rf_rd[s] = rf[src_addr[s]];
            end
        end
    end

`ifdef ID_BYPASS_EN

    logic [1:0]    hit_ready;
    logic [DW-1:0] hit_data [2];

    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_hit[s]   = 1'b0;
            hit_ready[s] = 1'b1;
            hit_data[s]  = '0;
            for (int i = NFWD - 1; i >= 0; i--) begin
                if (src_en[s]
                    && (src_addr[s] != '0)
                    && fwd_valid[i]
                    && fwd_we[i]
                    && (fwd_addr[i*AW +: AW] == src_addr[s])) begin
                    src_hit[s]   = 1'b1;
                    hit_ready[s] = fwd_ready[i];
                    hit_data[s]  = fwd_data[i*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_haz[s] = src_hit[s] & ~hit_ready[s];
            if (src_addr[s] == '0) begin
                opnd[s] = '0;
            end else if (src_hit[s]) begin
                opnd[s] = hit_data[s];
            end else begin
                opnd[s] = rf_rd[s];
            end
        end
    end

`else

    // Without forwarding, data and readiness of producers are irrelevant.
    logic unused_fwd;
    assign unused_fwd = ^{fwd_data, fwd_ready};

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_hit[s] = 1'b0;
            for (int i = 0; i < NFWD; i++) begin
                if (src_en[s]
                    && (src_addr[s] != '0)
                    && fwd_valid[i]
                    && fwd_we[i]
                    && (fwd_addr[i*AW +: AW] == src_addr[s])) begin
                    src_hit[s] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_haz[s] = src_hit[s];
            opnd[s]    = rf_rd[s];
        end
    end

`endif

    // Handshake
    assign hazard         = |src_haz;
    assign id_ready_go    = ~hazard;
    assign id_allowin     = ~id_valid | (id_ready_go & ex_allowin);
    assign id_to_ex_valid = id_valid & id_ready_go & ~id_flush;
    assign id_stall       = id_valid & ~id_ready_go;

    assign id_reg = {slot_payload, slot_dest, slot_gr_we,
                     opnd[0], opnd[1]};

    // Slot register: flush beats any offer from IF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid       <= 1'b0;
            slot_payload   <= '0;
            slot_src1_en   <= 1'b0;
            slot_src1_addr <= '0;
            slot_src2_en   <= 1'b0;
            slot_src2_addr <= '0;
            slot_gr_we     <= 1'b0;
            slot_dest      <= '0;
        end else if (id_flush) begin
            id_valid <= 1'b0;
        end else if (id_allowin) begin
            id_valid <= if_to_id_valid;
            if (if_to_id_valid) begin
                slot_payload   <= if_payload;
                slot_src1_en   <= if_src1_en;
                slot_src1_addr <= if_src1_addr;
                slot_src2_en   <= if_src2_en;
                slot_src2_addr <= if_src2_addr;
                slot_gr_we     <= if_gr_we;
                slot_dest      <= if_dest;
            end
        end
    end

endmodule

// File: tb/tb_id_bypass_stage.sv
// Bench for id_bypass_stage: vector table plus multi-cycle sequences.
// Expectations follow the ID_BYPASS_EN setting of the build.

module tb_id_bypass_stage;

    localparam bit BYP =
`ifdef ID_BYPASS_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        if_to_id_valid;
    logic        id_allowin;
    logic [63:0] if_payload;
    logic        if_src1_en;
    logic [4:0]  if_src1_addr;
    logic        if_src2_en;
    logic [4:0]  if_src2_addr;
    logic        if_gr_we;
    logic [4:0]  if_dest;
    logic        id_flush;
    logic        ex_allowin;
    logic        id_to_ex_valid;
    logic [133:0] id_reg;
    logic        id_stall;
    logic [1:0]  fwd_valid;
    logic [1:0]  fwd_we;
    logic [9:0]  fwd_addr;
    logic [1:0]  fwd_ready;
    logic [63:0] fwd_data;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_wdata;

    int checks = 0;
    int errors = 0;

    id_bypass_stage dut (
        .clk            (clk),
        .reset          (reset),
        .if_to_id_valid (if_to_id_valid),
        .id_allowin     (id_allowin),
        .if_payload     (if_payload),
        .if_src1_en     (if_src1_en),
        .if_src1_addr   (if_src1_addr),
        .if_src2_en     (if_src2_en),
        .if_src2_addr   (if_src2_addr),
        .if_gr_we       (if_gr_we),
        .if_dest        (if_dest),
        .id_flush       (id_flush),
        .ex_allowin     (ex_allowin),
        .id_to_ex_valid (id_to_ex_valid),
        .id_reg         (id_reg),
        .id_stall       (id_stall),
        .fwd_valid      (fwd_valid),
        .fwd_we         (fwd_we),
        .fwd_addr       (fwd_addr),
        .fwd_ready      (fwd_ready),
        .fwd_data       (fwd_data),
        .wb_we          (wb_we),
        .wb_addr        (wb_addr),
        .wb_wdata       (wb_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not end");
        $fatal(1);
    end

    wire [31:0] s2_val  = id_reg[31:0];
    wire [31:0] s1_val  = id_reg[63:32];
    wire        o_gr_we = id_reg[64];
    wire [4:0]  o_dest  = id_reg[69:65];
    wire [63:0] o_pay   = id_reg[133:70];

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        s1en;
        logic [4:0]  s1;
        logic        s2en;
        logic [4:0]  s2;
        logic [1:0]  fv;
        logic [1:0]  fw;
        logic [1:0]  fr;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        stall;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vt [9];

    task automatic offer(input logic [63:0] pay,
                         input logic s1en, input logic [4:0] s1,
                         input logic s2en, input logic [4:0] s2,
                         input logic [4:0] dest, input logic we);
        if_to_id_valid = 1'b1;
        if_payload     = pay;
        if_src1_en     = s1en;
        if_src1_addr   = s1;
        if_src2_en     = s2en;
        if_src2_addr   = s2;
        if_dest        = dest;
        if_gr_we       = we;
    endtask

    task automatic fwd_clear();
        fwd_valid = '0;
        fwd_we    = '0;
        fwd_addr  = '0;
        fwd_ready = '0;
        fwd_data  = '0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we    = 1'b1;
        wb_addr  = a;
        wb_wdata = d;
        @(posedge clk);
        #1;
        wb_we    = 1'b0;
    endtask

    initial begin
        // Table: priority, masking, r0, disabled sources, invalid channels
        vt[0] = '{1, 5, 1, 7, 2'b00, 2'b00, 2'b00, 0, 0,
                  32'h11, 32'h22, 0, 32'h55, 32'h77};
        vt[1] = '{1, 5, 1, 9, 2'b11, 2'b11, 2'b11, 5, 5,
                  32'h11, 32'h22, !BYP,
                  BYP ? 32'h11 : 32'h55, 32'h99};
        vt[2] = '{1, 5, 1, 7, 2'b11, 2'b11, 2'b11, 3, 7,
                  32'h11, 32'h22, !BYP,
                  32'h55, BYP ? 32'h22 : 32'h77};
        vt[3] = '{1, 3, 1, 7, 2'b11, 2'b11, 2'b10, 7, 7,
                  32'h11, 32'h22, 1,
                  32'h33, BYP ? 32'h11 : 32'h77};
        vt[4] = '{1, 5, 1, 9, 2'b11, 2'b11, 2'b01, 5, 5,
                  32'h11, 32'h22, !BYP,
                  BYP ? 32'h11 : 32'h55, 32'h99};
        vt[5] = '{1, 0, 1, 3, 2'b01, 2'b01, 2'b00, 0, 0,
                  32'h5, 32'h22, 0, 32'h0, 32'h33};
        vt[6] = '{0, 5, 1, 9, 2'b01, 2'b01, 2'b00, 5, 0,
                  32'h11, 32'h22, 0, 32'h55, 32'h99};
        vt[7] = '{1, 3, 1, 7, 2'b01, 2'b00, 2'b00, 7, 0,
                  32'h11, 32'h22, 0, 32'h33, 32'h77};
        vt[8] = '{1, 9, 1, 3, 2'b00, 2'b01, 2'b00, 9, 0,
                  32'h11, 32'h22, 0, 32'h99, 32'h33};

        reset          = 1'b1;
        if_to_id_valid = 1'b0;
        if_payload     = '0;
        if_src1_en     = 1'b0;
        if_src1_addr   = '0;
        if_src2_en     = 1'b0;
        if_src2_addr   = '0;
        if_gr_we       = 1'b0;
        if_dest        = '0;
        id_flush       = 1'b0;
        ex_allowin     = 1'b1;
        wb_we          = 1'b0;
        wb_addr        = '0;
        wb_wdata       = '0;
        fwd_clear();

        // Reset state
        #2;
        chk("rst_to_ex", 64'(id_to_ex_valid), 64'h0);
        chk("rst_stall", 64'(id_stall), 64'h0);
        chk("rst_allowin", 64'(id_allowin), 64'h1);
        chk("rst_payload", o_pay, 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        wb_write(5'd3, 32'h33);
        wb_write(5'd5, 32'h55);
        wb_write(5'd7, 32'h77);
        wb_write(5'd9, 32'h99);

        // Table vectors: accept, then evaluate against channel state
        for (int i = 0; i < 9; i++) begin
            offer({32'hA5A5_0000, 32'(i)},
                  vt[i].s1en, vt[i].s1, vt[i].s2en, vt[i].s2,
                  5'(i + 1), i[0]);
            @(posedge clk);
            #1;
            if_to_id_valid = 1'b0;
            fwd_valid = vt[i].fv;
            fwd_we    = vt[i].fw;
            fwd_ready = vt[i].fr;
            fwd_addr  = {vt[i].a1, vt[i].a0};
            fwd_data  = {vt[i].d1, vt[i].d0};
            @(negedge clk);
            chk($sformatf("v%0d_to_ex", i),
                64'(id_to_ex_valid), 64'(!vt[i].stall));
            chk($sformatf("v%0d_stall", i),
                64'(id_stall), 64'(vt[i].stall));
            chk($sformatf("v%0d_allowin", i),
                64'(id_allowin), 64'(!vt[i].stall));
            chk($sformatf("v%0d_src1", i), 64'(s1_val), 64'(vt[i].e1));
            chk($sformatf("v%0d_src2", i), 64'(s2_val), 64'(vt[i].e2));
            chk($sformatf("v%0d_payload", i), o_pay,
                {32'hA5A5_0000, 32'(i)});
            chk($sformatf("v%0d_dest_we", i), 64'({o_dest, o_gr_we}),
                64'({5'(i + 1), i[0]}));
            id_flush = 1'b1;
            fwd_clear();
            @(posedge clk);
            #1;
            id_flush = 1'b0;
        end

        // Load-use held over several cycles, later offer blocked
        offer(64'h1111, 1'b0, 5'd0, 1'b1, 5'd7, 5'd4, 1'b1);
        fwd_valid = 2'b01;
        fwd_we    = 2'b01;
        fwd_addr  = {5'd0, 5'd7};
        fwd_ready = 2'b00;
        @(posedge clk);
        #1;
        offer(64'h2222, 1'b1, 5'd5, 1'b1, 5'd3, 5'd6, 1'b0);
        @(negedge clk);
        chk("lu_stall", 64'(id_stall), 64'h1);
        chk("lu_to_ex", 64'(id_to_ex_valid), 64'h0);
        chk("lu_allowin", 64'(id_allowin), 64'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lu_stall2", 64'(id_stall), 64'h1);
        chk("lu_hold_payload", o_pay, 64'h1111);
        fwd_ready = 2'b01;
        fwd_data  = {32'h0, 32'hDEAD};
        #1;
        chk("lu_ready_to_ex", 64'(id_to_ex_valid), 64'(BYP));
        chk("lu_ready_src2", 64'(s2_val),
            BYP ? 64'hDEAD : 64'h77);
        fwd_clear();
        #1;
        chk("lu_clear_to_ex", 64'(id_to_ex_valid), 64'h1);
        chk("lu_clear_src2", 64'(s2_val), 64'h77);
        chk("lu_clear_allowin", 64'(id_allowin), 64'h1);
        @(posedge clk);
        #1;
        if_to_id_valid = 1'b0;
        @(negedge clk);
        chk("next_payload", o_pay, 64'h2222);
        chk("next_to_ex", 64'(id_to_ex_valid), 64'h1);
        chk("next_src1", 64'(s1_val), 64'h55);
        chk("next_src2", 64'(s2_val), 64'h33);

        // EX backpressure, then write-through on the held slot
        ex_allowin = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_to_ex", 64'(id_to_ex_valid), 64'h1);
        chk("bp_allowin", 64'(id_allowin), 64'h0);
        chk("bp_payload", o_pay, 64'h2222);
        wb_we    = 1'b1;
        wb_addr  = 5'd3;
        wb_wdata = 32'hCAFE;
        #1;
        chk("wt_src2", 64'(s2_val), 64'hCAFE);
        chk("wt_src1", 64'(s1_val), 64'h55);
        @(posedge clk);
        #1;
        wb_we = 1'b0;
        @(negedge clk);
        chk("wt_stored", 64'(s2_val), 64'hCAFE);

        // Flush with an offer pending: both are dropped
        offer(64'h3333, 1'b0, 5'd0, 1'b0, 5'd0, 5'd1, 1'b1);
        id_flush   = 1'b1;
        ex_allowin = 1'b1;
        #1;
        chk("fl_to_ex", 64'(id_to_ex_valid), 64'h0);
        @(posedge clk);
        #1;
        id_flush       = 1'b0;
        if_to_id_valid = 1'b0;
        @(negedge clk);
        chk("fl_next_to_ex", 64'(id_to_ex_valid), 64'h0);
        chk("fl_next_stall", 64'(id_stall), 64'h0);
        chk("fl_next_allowin", 64'(id_allowin), 64'h1);

        // Reset asserted mid-stall
        offer(64'h4444, 1'b1, 5'd7, 1'b0, 5'd0, 5'd2, 1'b1);
        fwd_valid = 2'b01;
        fwd_we    = 2'b01;
        fwd_addr  = {5'd0, 5'd7};
        fwd_ready = 2'b00;
        @(posedge clk);
        #1;
        if_to_id_valid = 1'b0;
        @(negedge clk);
        chk("rs_pre_stall", 64'(id_stall), 64'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("rs_stall", 64'(id_stall), 64'h0);
        chk("rs_to_ex", 64'(id_to_ex_valid), 64'h0);
        chk("rs_allowin", 64'(id_allowin), 64'h1);
        chk("rs_payload", o_pay, 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        fwd_clear();
        @(negedge clk);
        chk("rs_after_to_ex", 64'(id_to_ex_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
